// File: rtl/instr_encoder.sv
// Program-load encoder: turns field-level instruction requests into 32-bit
// ARM-style words and streams them through a 4-deep FIFO into instruction memory.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        last,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [3:0]  req_cond,
  input  logic [3:0]  req_cmd,
  input  logic        req_s,
  input  logic        req_useimm,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rd,
  input  logic [3:0]  req_rm,
  input  logic [23:0] req_imm,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [6:0]  word_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] KIND_DP  = 2'b00;
  localparam logic [1:0] KIND_LDR = 2'b01;
  localparam logic [1:0] KIND_STR = 2'b10;

  state_t      state;
  logic [31:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  fifo_cnt;
  logic [5:0]  word_idx;
  logic [6:0]  acc_count;
  logic [31:0] enc_word;
  logic        s_eff;
  logic        fifo_full;
  logic        fifo_empty;
  logic        active;
  logic        accept;
  logic        write_done;

  // Encoder: compare-class ALU ops always set the flags.
  always_comb begin
    enc_word = '0;
    s_eff    = req_s | (req_cmd == 4'b1010) | (req_cmd == 4'b1011);
    case (req_kind)
      KIND_DP:
        enc_word = {req_cond, 2'b00, req_useimm, req_cmd, s_eff, req_rn, req_rd,
                    req_useimm ? req_imm[11:0] : {8'h00, req_rm}};
      KIND_LDR:
        enc_word = {req_cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                    req_rn, req_rd, req_imm[11:0]};
      KIND_STR:
        enc_word = {req_cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    req_rn, req_rd, req_imm[11:0]};
      default:
        enc_word = {req_cond, 3'b101, 1'b0, req_imm};
    endcase
  end

  assign fifo_full  = (fifo_cnt == 3'd4);
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign active     = (state == S_RUN) || (state == S_DRAIN);

  // Ready is derived from registered occupancy only, so a full FIFO blocks
  // even when a pop happens in the same cycle.
  assign req_ready  = (state == S_RUN) && !fifo_full && !acc_count[6];
  assign accept     = req_valid && req_ready;

  assign imem_we    = active && !fifo_empty;
  assign write_done = imem_we && imem_ready;
  assign imem_addr  = {word_idx, 2'b00};
  assign imem_wdata = imem_we ? fifo_mem[rd_ptr] : '0;

  assign busy       = active;
  assign done       = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      word_idx   <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      acc_count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr    <= wr_ptr + 2'd1;
        acc_count <= acc_count + 7'd1;
      end
      if (write_done) begin
        rd_ptr     <= rd_ptr + 2'd1;
        word_idx   <= word_idx + 6'd1;
        word_count <= word_count + 7'd1;
      end
      case ({accept, write_done})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            word_idx   <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            acc_count  <= '0;
          end
        end
        S_RUN: begin
          // The 64th accepted request without last closes the load as overflow.
          if (accept && (last || (acc_count == 7'd63))) begin
            state    <= S_DRAIN;
            overflow <= !last;
          end
        end
        S_DRAIN: begin
          if (fifo_empty && !write_done) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have request ports: start in 1, begin program load; last in 1, qualifies final request; req_valid in 1; req_ready out 1.
REQ-003 SHALL have field inputs: req_kind in 2 (00 DP, 01 LDR, 10 STR, 11 B); req_cond in 4; req_cmd in 4, DP ALU cmd; req_s in 1; req_useimm in 1; req_rn, req_rd, req_rm in 4 each; req_imm in 24.
REQ-004 SHALL have write-port outputs: imem_we out 1; imem_addr out 8, byte address; imem_wdata out 32; imem_ready in 1.
REQ-005 SHALL have status outputs: busy out 1; done out 1; overflow out 1, sticky; word_count out 7, words written.

Function
REQ-006 SHALL implement FSM IDLE, RUN, DRAIN, DONE; reset enters IDLE.
REQ-007 Transitions SHALL be: IDLE/DONE + start -> RUN; RUN + accepted request with last=1 -> DRAIN; DRAIN + FIFO empty + no write this cycle -> DONE; start ignored in RUN/DRAIN.
REQ-008 Entering RUN SHALL clear word index, word_count, overflow, done.
REQ-009 req_ready SHALL be 1 only in RUN with FIFO not full and accepted-request count < 64; a transfer occurs when req_valid & req_ready at a rising edge.
REQ-010 DP encoding SHALL be {cond, 2'b00, I=req_useimm, cmd, S, Rn, Rd, src2}; src2 = req_imm[11:0] when I=1, else {8'h00, Rm}.
REQ-011 S SHALL be forced to 1 when req_cmd is 1010 (CMP) or 1011 (CMN), else req_s.
REQ-012 LDR/STR encoding SHALL be {cond, 2'b01, 1'b0, P=1, U=1, B=0, W=0, L, Rn, Rd, req_imm[11:0]}, L=1 for LDR, 0 for STR.
REQ-013 B encoding SHALL be {cond, 3'b101, 1'b0, req_imm[23:0]}.
REQ-014 Encoded words SHALL enter a 4-entry FIFO at the accepting edge; no same-cycle bypass to imem_wdata.
REQ-015 imem_we SHALL be 1 whenever FIFO non-empty in RUN or DRAIN; imem_wdata = FIFO head; imem_addr = {word index, 2'b00}.
REQ-016 Write completes when imem_we & imem_ready; then FIFO pops, word index and word_count increment by 1.
REQ-017 imem_we, imem_addr, imem_wdata SHALL hold stable while imem_we=1 and imem_ready=0.
REQ-018 Minimum latency: request accepted at edge N -> imem_we=1 during cycle N+1; sustained throughput one word per cycle with imem_ready=1.
REQ-019 Simultaneous push and pop SHALL keep occupancy unchanged; req_ready SHALL not depend on same-cycle pop (full FIFO blocks).
REQ-020 After 64 accepted requests without last, req_ready SHALL drop, overflow SHALL set, FSM SHALL go to DRAIN.
REQ-021 Word index is 6 bits and SHALL not wrap within one load (bounded by REQ-020).
REQ-022 busy SHALL equal (state==RUN or DRAIN); done SHALL be 1 only in DONE.

Reset
REQ-023 Reset SHALL force IDLE, flush FIFO, zero word index, word_count, overflow, done, busy, imem_we, req_ready, imem_addr, imem_wdata.
REQ-024 Reset mid-write SHALL abort immediately; imem_we=0 the cycle after the reset edge.

Verification
REQ-025 DP: start, then req cond=1110, cmd=0100, I=1, S=0, Rn=1, Rd=2, imm=0x005 -> imem_wdata=0xE2812005, imem_addr=0x00, one cycle after accept.
REQ-026 CMP/LDR/B: cmd=1010 reg Rn=3 Rm=4 S=0 -> 0xE1530004; LDR Rd=5 Rn=6 imm=0x008 -> 0xE5965008; B cond=0000 imm=0xFFFFFE -> 0x0AFFFFFE.
REQ-027 Backpressure: imem_ready=0, 5 back-to-back requests -> 4 accepted, req_ready=0, outputs stable; release -> addresses 0x00,0x04,0x08,0x0C,0x10 in order.
REQ-028 Completion: 3 requests, last on third, imem_ready=1 -> word_count=3, done=1 one cycle after final write, busy=0.
REQ-029 Overflow: 65 requests, no last -> 64 written (final addr 0xFC), overflow=1, done=1, 65th never accepted.
REQ-030 Reset with FIFO holding 3 words -> imem_we=0, word_count=0, state IDLE; subsequent start reloads from addr 0x00.
